// File: rtl/pc_ctrl_pkg.sv
// Shared control types and default dimensions for the pulse-compression datapath.
package pc_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_COEFF,
    ARMED,
    STREAM,
    FLUSH,
    DRAIN
  } state_t;

  localparam int unsigned DEF_DATA_WIDTH   = 12;
  localparam int unsigned DEF_FRAME_LENGTH = 5000;
  localparam int unsigned DEF_COEFF_LENGTH = 800;
  localparam int unsigned DEF_PIPE_LATENCY = 40;
  localparam int unsigned DEF_CNT_WIDTH    = 16;

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-depth delay of the FIR input valid, aligning it with the magnitude output.
module valid_delay_line
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_PIPE_LATENCY
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] taps;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      taps <= '0;
    end else if (clear) begin
      taps <= '0;
    end else begin
      taps[0] <= d;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        taps[i] <= taps[i-1];
      end
    end
  end

  assign q = taps[DEPTH-1];

endmodule

// File: rtl/pc_frame_sequencer.sv
// Sequences coefficient load, per-trigger frame gating, tap flush and output
// framing for the pulse-compression filter.
module pc_frame_sequencer
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned FRAME_LENGTH = DEF_FRAME_LENGTH,
  parameter int unsigned COEFF_LENGTH = DEF_COEFF_LENGTH,
  parameter int unsigned PIPE_LATENCY = DEF_PIPE_LATENCY,
  parameter int unsigned CNT_WIDTH    = DEF_CNT_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  coeff_done,
  input  logic                  trigger,
  input  logic                  adc_valid,
  input  logic [DATA_WIDTH-1:0] adc_data,
  output logic                  coeff_load_en,
  output logic                  data_load_en,
  output logic                  stop_data_load,
  output logic [DATA_WIDTH-1:0] fir_data,
  output logic                  fir_data_valid,
  output logic                  out_valid,
  output logic                  frame_done,
  output logic                  armed,
  output logic                  underrun,
  output logic                  trig_miss,
  output logic [CNT_WIDTH-1:0]  sample_count
);

  localparam logic [CNT_WIDTH-1:0] LAST_SLOT  = CNT_WIDTH'(FRAME_LENGTH - 1);
  localparam logic [CNT_WIDTH-1:0] LAST_FLUSH = CNT_WIDTH'((COEFF_LENGTH > 1) ? COEFF_LENGTH - 2 : 0);
  localparam logic [CNT_WIDTH-1:0] LAST_DRAIN = CNT_WIDTH'(PIPE_LATENCY - 1);

  state_t                 state, state_next;
  logic [CNT_WIDTH-1:0]   cnt, cnt_next;

  logic                   coeff_load_en_d, data_load_en_d, stop_data_load_d;
  logic [DATA_WIDTH-1:0]  fir_data_d;
  logic                   fir_data_valid_d, frame_done_d, armed_d;
  logic                   underrun_d, trig_miss_d;
  logic [CNT_WIDTH-1:0]   sample_count_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (abort) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state)
        IDLE:       if (start) state_next = LOAD_COEFF;
        LOAD_COEFF: if (coeff_done) state_next = ARMED;
        ARMED: begin
          if (trigger) begin
            state_next = STREAM;
            cnt_next   = '0;
          end
        end
        STREAM: begin
          if (cnt == LAST_SLOT) begin
            state_next = (COEFF_LENGTH > 1) ? FLUSH : DRAIN;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
        FLUSH: begin
          if (cnt == LAST_FLUSH) begin
            state_next = DRAIN;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (cnt == LAST_DRAIN) begin
            state_next = ARMED;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Outputs are decoded from the current state and registered, so each one
  // lags the state it describes by a clock: trigger at T gives the first slot at T+1.
  always_comb begin
    coeff_load_en_d  = 1'b0;
    data_load_en_d   = 1'b0;
    stop_data_load_d = 1'b0;
    fir_data_d       = '0;
    fir_data_valid_d = 1'b0;
    frame_done_d     = 1'b0;
    armed_d          = 1'b0;
    underrun_d       = underrun;
    trig_miss_d      = trig_miss;
    sample_count_d   = sample_count;

    if (state == IDLE && start && !abort) begin
      underrun_d  = 1'b0;
      trig_miss_d = 1'b0;
    end
    if (trigger && state != ARMED) trig_miss_d = 1'b1;

    if (abort) begin
      sample_count_d = '0;
    end else begin
      case (state)
        LOAD_COEFF: begin
          coeff_load_en_d = 1'b1;
          data_load_en_d  = 1'b1;
        end
        ARMED: begin
          data_load_en_d = 1'b1;
          armed_d        = 1'b1;
          if (trigger) sample_count_d = '0;
        end
        STREAM: begin
          data_load_en_d   = 1'b1;
          fir_data_valid_d = 1'b1;
          sample_count_d   = sample_count + 1'b1;
          if (adc_valid) fir_data_d = adc_data;
          else           underrun_d = 1'b1;
        end
        FLUSH: begin
          data_load_en_d   = 1'b1;
          fir_data_valid_d = 1'b1;
          stop_data_load_d = (cnt == LAST_FLUSH);
        end
        DRAIN: begin
          data_load_en_d = 1'b1;
          frame_done_d   = (cnt == LAST_DRAIN);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      coeff_load_en  <= 1'b0;
      data_load_en   <= 1'b0;
      stop_data_load <= 1'b0;
      fir_data       <= '0;
      fir_data_valid <= 1'b0;
      frame_done     <= 1'b0;
      armed          <= 1'b0;
      underrun       <= 1'b0;
      trig_miss      <= 1'b0;
      sample_count   <= '0;
    end else begin
      coeff_load_en  <= coeff_load_en_d;
      data_load_en   <= data_load_en_d;
      stop_data_load <= stop_data_load_d;
      fir_data       <= fir_data_d;
      fir_data_valid <= fir_data_valid_d;
      frame_done     <= frame_done_d;
      armed          <= armed_d;
      underrun       <= underrun_d;
      trig_miss      <= trig_miss_d;
      sample_count   <= sample_count_d;
    end
  end

  valid_delay_line #(
    .DEPTH(PIPE_LATENCY)
  ) u_valid_delay (
    .clock(clock),
    .reset(reset),
    .clear(abort),
    .d    (fir_data_valid),
    .q    (out_valid)
  );

endmodule

// File: tb/tb_pc_frame_sequencer.sv
// Directed-plus-random bench for pc_frame_sequencer against a frame-timeline reference model.
module tb_pc_frame_sequencer;

  localparam int DW = 12;
  localparam int FL = 8;
  localparam int CL = 4;
  localparam int PL = 5;
  localparam int CW = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0, abort = 1'b0, coeff_done = 1'b0, trigger = 1'b0, adc_valid = 1'b0;
  logic [DW-1:0] adc_data = '0;
  logic          coeff_load_en, data_load_en, stop_data_load, fir_data_valid;
  logic          out_valid, frame_done, armed, underrun, trig_miss;
  logic [DW-1:0] fir_data;
  logic [CW-1:0] sample_count;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  pc_frame_sequencer #(
    .DATA_WIDTH  (DW),
    .FRAME_LENGTH(FL),
    .COEFF_LENGTH(CL),
    .PIPE_LATENCY(PL),
    .CNT_WIDTH   (CW)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .coeff_done    (coeff_done),
    .trigger       (trigger),
    .adc_valid     (adc_valid),
    .adc_data      (adc_data),
    .coeff_load_en (coeff_load_en),
    .data_load_en  (data_load_en),
    .stop_data_load(stop_data_load),
    .fir_data      (fir_data),
    .fir_data_valid(fir_data_valid),
    .out_valid     (out_valid),
    .frame_done    (frame_done),
    .armed         (armed),
    .underrun      (underrun),
    .trig_miss     (trig_miss),
    .sample_count  (sample_count)
  );

  // Reference model: a mode plus the trigger timestamp; frame phases follow
  // from the offset to the trigger.
  typedef enum {M_IDLE, M_LOAD, M_READY, M_FRAME} mode_t;
  mode_t         m_mode = M_IDLE;
  int            k = 0;
  int            trig_at = 0;
  int            clear_at = -1000;
  bit            vhist [0:4095];
  logic          e_coeff, e_dload, e_stop, e_fvalid, e_done, e_armed, e_oval;
  logic          e_under = 1'b0, e_miss = 1'b0;
  logic [DW-1:0] e_fdata;
  int            e_count = 0;

  task automatic model_zero();
    e_coeff = 0; e_dload = 0; e_stop = 0; e_fdata = '0; e_fvalid = 0;
    e_done = 0; e_armed = 0; e_oval = 0;
  endtask

  task automatic model_step();
    int d;
    model_zero();
    if (reset) begin
      m_mode = M_IDLE; e_under = 0; e_miss = 0; e_count = 0; clear_at = k;
    end else begin
      if (m_mode == M_IDLE && start && !abort) begin
        e_under = 0; e_miss = 0;
      end
      if (trigger && m_mode != M_READY) e_miss = 1;
      if (abort) begin
        m_mode = M_IDLE; e_count = 0; clear_at = k;
      end else begin
        case (m_mode)
          M_IDLE: if (start) m_mode = M_LOAD;
          M_LOAD: begin
            e_coeff = 1; e_dload = 1;
            if (coeff_done) m_mode = M_READY;
          end
          M_READY: begin
            e_dload = 1; e_armed = 1;
            if (trigger) begin
              m_mode = M_FRAME; trig_at = k; e_count = 0;
            end
          end
          M_FRAME: begin
            d = k - trig_at;
            e_dload = 1;
            if (d <= FL) begin
              e_fvalid = 1; e_count++;
              if (adc_valid) e_fdata = adc_data;
              else           e_under = 1;
            end else if (d < FL + CL) begin
              e_fvalid = 1; e_stop = (d == FL + CL - 1);
            end else if (d == FL + CL - 1 + PL) begin
              e_done = 1; m_mode = M_READY;
            end
          end
          default: ;
        endcase
      end
    end
    vhist[k] = e_fvalid;
    if (k >= PL && k - PL > clear_at) e_oval = vhist[k-PL];
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s at step %0d: observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("coeff_load_en",  32'(coeff_load_en),  32'(e_coeff));
    chk("data_load_en",   32'(data_load_en),   32'(e_dload));
    chk("stop_data_load", 32'(stop_data_load), 32'(e_stop));
    chk("fir_data",       32'(fir_data),       32'(e_fdata));
    chk("fir_data_valid", 32'(fir_data_valid), 32'(e_fvalid));
    chk("out_valid",      32'(out_valid),      32'(e_oval));
    chk("frame_done",     32'(frame_done),     32'(e_done));
    chk("armed",          32'(armed),          32'(e_armed));
    chk("underrun",       32'(underrun),       32'(e_under));
    chk("trig_miss",      32'(trig_miss),      32'(e_miss));
    chk("sample_count",   32'(sample_count),   32'(e_count));
  endtask

  task automatic tick(input logic s, input logic a, input logic cd, input logic tr,
                      input logic av, input logic [DW-1:0] ad);
    @(negedge clock);
    start = s; abort = a; coeff_done = cd; trigger = tr; adc_valid = av; adc_data = ad;
    @(posedge clock);
    #1;
    k++;
    model_step();
    check_all();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    tick(0, 0, 0, 0, 0, '0);
    tick(0, 0, 0, 0, 0, '0);
    reset = 1'b0;
    tick(0, 0, 0, 1, 1, DW'($urandom));

    // coefficient load, coeff_done six cycles after start, trigger miss mid-load
    tick(1, 0, 0, 0, 0, '0);
    for (int i = 1; i <= 6; i++) tick(0, 0, (i == 6), (i == 3), 0, '0);
    tick(0, 0, 1, 0, 0, '0);
    tick(0, 0, 1, 0, 0, '0);

    // full frame with continuous data, trigger during flush
    tick(0, 0, 1, 1, 1, DW'($urandom));
    for (int i = 1; i <= FL + CL + PL; i++) tick(0, 0, 1, (i == FL + 2), 1, DW'($urandom));

    // underrun on the third slot plus random gaps; start outside IDLE ignored
    tick(0, 0, 1, 1, 1, DW'($urandom));
    for (int i = 1; i <= FL + CL + PL; i++)
      tick(1'($urandom_range(0, 1)), 0, 1, 0, (i != 3) && ($urandom_range(0, 3) != 0), DW'($urandom));

    // back-to-back triggers at the minimum spacing
    for (int i = 0; i < 3 * (FL + CL + PL) + 2; i++)
      tick(0, 0, 1, 1, ($urandom_range(0, 5) != 0), DW'($urandom));
    for (int i = 0; i < FL + CL + PL + 2; i++) tick(0, 0, 1, 0, 1, DW'($urandom));

    // abort coincident with trigger in ARMED
    tick(1, 1, 1, 1, 1, DW'($urandom));
    for (int i = 0; i < PL + 3; i++) tick(0, 0, 1, 0, 1, DW'($urandom));

    // reload clears sticky flags, then a random frame aborted mid-stream
    tick(1, 0, 0, 0, 0, '0);
    tick(0, 0, 0, 0, 0, '0);
    tick(0, 0, 1, 0, 0, '0);
    tick(0, 0, 1, 1, 1, DW'($urandom));
    for (int i = 1; i <= 4; i++) tick(0, 0, 1, 0, 1'($urandom_range(0, 1)), DW'($urandom));
    tick(0, 1, 1, 0, 1, DW'($urandom));
    for (int i = 0; i < PL + 2; i++) tick(0, 0, 1, 0, 1, DW'($urandom));

    // asynchronous reset mid-stream
    tick(1, 0, 0, 0, 0, '0);
    tick(0, 0, 1, 0, 0, '0);
    tick(0, 0, 1, 1, 1, DW'($urandom));
    for (int i = 1; i <= 4; i++) tick(0, 0, 1, 0, 1, DW'($urandom));
    reset = 1'b1;
    #1;
    model_zero();
    m_mode = M_IDLE; e_under = 0; e_miss = 0; e_count = 0; clear_at = k;
    check_all();
    tick(0, 0, 1, 0, 1, DW'($urandom));
    reset = 1'b0;
    for (int i = 0; i < FL + CL + PL + 2; i++) tick(0, 0, 1, 0, 1, DW'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
